// File: rtl/rr_decode_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter_if
// Bundles the request/grant signals of the round-robin decode arbiter.
//   req       [7:0]  request vector, req[i] high while requester i wants the resource
//   done             single-cycle release pulse from the current owner
//   gnt       [7:0]  one-hot grant (registered)
//   gnt_idx   [2:0]  binary index of the owner
//   gnt_valid        a grant is active
//   timeout          one-cycle pulse when a grant is force-released by the hold limit
// master: requester side (drives req/done); slave: the arbiter.
// ---------------------------------------------------------------------------
interface rr_decode_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter
// Round-robin arbiter sharing one 3-to-8 select resource among eight
// requesters. A grant is held until the owner pulses done, drops its request,
// or the hold limit MAX_HOLD expires (0 disables the limit). The winner is
// presented as a one-hot vector and as a binary index; all outputs are
// registered.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_decode_arbiter_if.slave (req, done in; gnt, gnt_idx,
//          gnt_valid, timeout out)
// ---------------------------------------------------------------------------
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic               clk,
    input logic               rst_n,
    rr_decode_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_e;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    // Last hold_cnt value of a grant: the owner has then held it MAX_HOLD cycles.
    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    logic       found;
    logic [2:0] win;
    logic [2:0] cand;
    logic       hold_hit;

    // Priority search starting at rr_ptr and wrapping mod 8.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = rr_ptr_q;
        for (int k = 0; k < 8; k++) begin
            cand = rr_ptr_q + 3'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // NOTE: every next-state signal gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_hit    = HOLD_EN && (hold_cnt_q == HOLD_LAST);

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (found) begin
                    state_d     = GRANT;
                    gnt_idx_d   = win;
                    gnt_d       = 8'b1 << win;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
                // All release causes merge into one release; timeout only
                // reflects the hold-limit cause.
                if (bus.done || !bus.req[gnt_idx_q] || hold_hit) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    rr_ptr_d    = gnt_idx_q + 3'd1;
                    timeout_d   = hold_hit;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_decode_arbiter
// Two arbiters share clock, reset and stimulus: dut_a with MAX_HOLD=4 and
// dut_b with MAX_HOLD=0 (no hold limit). Each is compared every cycle with a
// behavioural model; directed vectors and sequences cover fairness, pointer
// wrap, simultaneous release, asynchronous reset and the hold limit.
// ---------------------------------------------------------------------------
module tb_rr_decode_arbiter;

    logic clk;
    logic rst_n;

    rr_decode_arbiter_if ifa ();
    rr_decode_arbiter_if ifb ();

    rr_decode_arbiter #(.MAX_HOLD(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    rr_decode_arbiter #(.MAX_HOLD(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy/owner/ptr as plain integers; held counts the cycles the current
    // owner has had the grant so far.
    int          m_busy  [2];
    int          m_owner [2];
    int          m_ptr   [2];
    int          m_held  [2];
    int          m_to    [2];
    int unsigned m_max   [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 0;
            m_owner[d] = 0;
            m_ptr[d]   = 0;
            m_held[d]  = 0;
            m_to[d]    = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [7:0] r, input logic dn);
        int found;
        m_to[d] = 0;
        if (m_busy[d] == 0) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                int i;
                i = (m_ptr[d] + k) % 8;
                if (found == 0 && r[i]) begin
                    found      = 1;
                    m_busy[d]  = 1;
                    m_owner[d] = i;
                    m_held[d]  = 1;
                end
            end
        end else begin
            if (m_max[d] != 0 && m_held[d] == int'(m_max[d])) m_to[d] = 1;
            if (dn || !r[m_owner[d]] || m_to[d] != 0) begin
                m_busy[d] = 0;
                m_ptr[d]  = (m_owner[d] + 1) % 8;
            end else begin
                m_held[d]++;
            end
        end
    endtask

    task automatic check_dut(input string tag, input int d, input logic [7:0] g,
                             input logic [2:0] idx, input logic v, input logic to);
        logic [7:0] eg;
        eg = (m_busy[d] != 0) ? (8'h01 << m_owner[d]) : 8'h00;
        check($sformatf("%s d%0d gnt", tag, d), 32'(g), 32'(eg));
        check($sformatf("%s d%0d gnt_idx", tag, d), 32'(idx), 32'(m_owner[d] % 8));
        check($sformatf("%s d%0d gnt_valid", tag, d), 32'(v), 32'(m_busy[d] != 0));
        check($sformatf("%s d%0d timeout", tag, d), 32'(to), 32'(m_to[d] != 0));
        check($sformatf("%s d%0d onehot0", tag, d), 32'($onehot0(g)), 32'd1);
        check($sformatf("%s d%0d gnt_vs_idx", tag, d),
              32'(v ? (g == (8'h01 << idx)) : (g == 8'h00)), 32'd1);
    endtask

    task automatic check_both(input string tag);
        check_dut(tag, 0, ifa.gnt, ifa.gnt_idx, ifa.gnt_valid, ifa.timeout);
        check_dut(tag, 1, ifb.gnt, ifb.gnt_idx, ifb.gnt_valid, ifb.timeout);
    endtask

    // Call at a falling edge: drive, let one rising edge pass, check at the
    // next falling edge.
    task automatic step(input logic [7:0] r, input logic dn, input string tag);
        ifa.req  = r;
        ifa.done = dn;
        ifb.req  = r;
        ifb.done = dn;
        @(posedge clk);
        model_step(0, r, dn);
        model_step(1, r, dn);
        @(negedge clk);
        check_both(tag);
    endtask

    // ---------------- directed vector table (dut_a) ----------------
    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] r, input logic dn, input logic [7:0] g,
                                input logic [2:0] i, input logic v, input logic t);
        vec_t x;
        x.req = r; x.done = dn; x.gnt = g; x.idx = i; x.valid = v; x.to = t;
        return x;
    endfunction

    initial begin
        int va, ta, vb, tbb;
        logic [7:0] r;
        logic       dn;

        m_max[0] = 4;
        m_max[1] = 0;
        model_reset();

        // Fairness: req=FF held, done one cycle after each grant.
        for (int i = 0; i <= 8; i++) begin
            vecs.push_back(mk(8'hFF, 1'b0, 8'h01 << (i % 8), 3'(i % 8), 1'b1, 1'b0));
            vecs.push_back(mk(8'hFF, 1'b1, 8'h00, 3'(i % 8), 1'b0, 1'b0));
        end
        // Wrap priority: release idx 6 (ptr=7), then 0x41 -> idx 0, then idx 6.
        vecs.push_back(mk(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0));
        vecs.push_back(mk(8'h40, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0));
        vecs.push_back(mk(8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0));
        vecs.push_back(mk(8'h41, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0));
        // Owner 3 withdraws together with done; done in IDLE ignored; ptr=4.
        vecs.push_back(mk(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0));

        // Reset
        rst_n    = 1'b1;
        ifa.req  = '0; ifa.done = 1'b0;
        ifb.req  = '0; ifb.done = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_both("reset");
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            step(vecs[n].req, vecs[n].done, $sformatf("vec%0d", n));
            check($sformatf("vec%0d tbl gnt", n), 32'(ifa.gnt), 32'(vecs[n].gnt));
            check($sformatf("vec%0d tbl idx", n), 32'(ifa.gnt_idx), 32'(vecs[n].idx));
            check($sformatf("vec%0d tbl valid", n), 32'(ifa.gnt_valid), 32'(vecs[n].valid));
            check($sformatf("vec%0d tbl timeout", n), 32'(ifa.timeout), 32'(vecs[n].to));
        end

        // Reset mid-grant: ptr is 5 here, req=04 wins idx 2.
        step(8'h04, 1'b0, "pre_rst");
        check("pre_rst gnt", 32'(ifa.gnt), 32'h04);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_both("async_rst");
        @(negedge clk);
        check_both("rst_held");
        rst_n = 1'b1;
        // With ptr back at 0, 0x84 must pick idx 2 (idx 7 if ptr stayed at 5).
        step(8'h84, 1'b0, "post_rst");
        check("post_rst idx", 32'(ifa.gnt_idx), 32'd2);
        check("post_rst gnt", 32'(ifa.gnt), 32'h04);
        step(8'h00, 1'b0, "post_rst_rel");

        // Hold limit: dut_a times out every 4 cycles, dut_b holds on.
        va = 0; ta = 0; vb = 0; tbb = 0;
        for (int c = 0; c < 12; c++) begin
            step(8'h10, 1'b0, $sformatf("hold%0d", c));
            va  += int'(ifa.gnt_valid);
            ta  += int'(ifa.timeout);
            vb  += int'(ifb.gnt_valid);
            tbb += int'(ifb.timeout);
        end
        check("hold a valid cycles", 32'(va), 32'd10);
        check("hold a timeouts", 32'(ta), 32'd2);
        check("hold b valid cycles", 32'(vb), 32'd12);
        check("hold b timeouts", 32'(tbb), 32'd0);
        for (int c = 0; c < 40; c++) step(8'h10, 1'b0, "long_hold");
        check("long_hold b valid", 32'(ifb.gnt_valid), 32'd1);
        step(8'h00, 1'b0, "long_hold_rel");

        // Randomized traffic against the model.
        r = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(3) == 0) r = 8'($urandom_range(255));
            if ($urandom_range(15) == 0) r = 8'h00;
            dn = ($urandom_range(4) == 0);
            step(r, dn, $sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
